// File: rtl/settings_pkg.sv
// Shared widths, command packet type and byteenable helper for the trans block.
package settings_pkg;
   localparam int DATA_W      = 64;
   localparam int ADDR_W      = 31;
   localparam int AMM_BURST_W = 11;
   localparam     ADDR_TYPE   = "BYTE";
   localparam int BE_W        = DATA_W / 8;
   localparam int ADDR_B_W    = $clog2(BE_W);
   localparam int MAX_LEN     = 2 ** (AMM_BURST_W - 1);

   typedef enum logic [1:0] {IDLE_S, WR_BURST_S, RD_CMD_S} state_t;

   // low_burst_bits[ADDR_B_W] flags a byte span that crosses a word boundary
   typedef struct packed {
      logic                pkt_type;     // 0 = write, 1 = read
      logic [ADDR_W-1:0]   word_addr;
      logic [ADDR_B_W:0]   low_burst_bits;
      logic [ADDR_B_W-1:0] start_offset;
      logic [ADDR_B_W-1:0] end_offset;
   } trans_struct_t;

   // First beat keeps bytes >= offset, last beat keeps bytes <= offset
   function automatic logic [BE_W-1:0] be_mask(input logic [ADDR_B_W-1:0] offset,
                                               input logic is_first);
      logic [BE_W-1:0] m;
      for (int i = 0; i < BE_W; i++)
         m[i] = is_first ? (i >= int'(offset)) : (i <= int'(offset));
      return m;
   endfunction
endpackage

// File: rtl/amm_be_gen.sv
// Byteenable for a given beat: first/last masks from the offsets, middle beats all ones.
module amm_be_gen
   import settings_pkg::*;
#(
   parameter ADDR_TYPE = "BYTE"
) (
   input  logic [ADDR_B_W-1:0]    i_start_off,
   input  logic [ADDR_B_W-1:0]    i_end_off,
   input  logic [AMM_BURST_W-1:0] i_beat,
   input  logic [AMM_BURST_W-1:0] i_len,
   output logic [BE_W-1:0]        o_be
);
   generate
      if (ADDR_TYPE == "BYTE") begin : g_byte
         // a single-beat burst is both first and last, so both masks apply
         always_comb begin
            o_be = '1;
            if (i_beat == '0)
               o_be = o_be & be_mask(i_start_off, 1'b1);
            if (i_beat == i_len - AMM_BURST_W'(1))
               o_be = o_be & be_mask(i_end_off, 1'b0);
         end
      end else begin : g_word
         logic w_unused;
         assign w_unused = ^{i_start_off, i_end_off, i_beat, i_len};
         assign o_be     = '1;
      end
   endgenerate
endmodule

// File: rtl/amm_trans_block.sv
// Executes one accepted command as a single Avalon-MM burst (pattern writes or read command).
module amm_trans_block
   import settings_pkg::*;
#(
   parameter ADDR_TYPE = settings_pkg::ADDR_TYPE
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   op_valid_i,
   input  trans_struct_t          op_pkt_i,
   output logic                   cmd_accept_ready_o,
   input  logic [AMM_BURST_W-2:0] burst_len_i,
   input  logic [31:0]            data_pattern_i,
   output logic                   busy_o,
   output logic [ADDR_W-1:0]      amm_address_o,
   output logic                   amm_read_o,
   output logic                   amm_write_o,
   output logic [DATA_W-1:0]      amm_writedata_o,
   output logic [BE_W-1:0]        amm_byteenable_o,
   output logic [AMM_BURST_W-1:0] amm_burstcount_o,
   input  logic                   amm_waitrequest_i
);
   localparam bit BYTE_MODE = (ADDR_TYPE == "BYTE");

   state_t                 r_state, w_state_nxt;
   logic                   r_ready, r_busy;
   logic [AMM_BURST_W-1:0] r_len, r_beat, w_len, w_base, w_beat_nxt;
   logic [ADDR_B_W-1:0]    r_start, r_end;
   logic [31:0]            r_pattern;
   logic [ADDR_W-1:0]      r_addr;
   logic [DATA_W-1:0]      r_wdata;
   logic [BE_W-1:0]        r_be, w_be;
   logic                   w_accept, w_beat_done, w_last;
   logic [ADDR_B_W-1:0]    w_be_start, w_be_end;
   logic [AMM_BURST_W-1:0] w_be_beat, w_be_len;
   logic                   w_unused;

   assign w_accept    = op_valid_i & r_ready;
   assign w_beat_done = (r_state == WR_BURST_S) & ~amm_waitrequest_i;
   assign w_last      = (r_beat == r_len - AMM_BURST_W'(1));
   assign w_beat_nxt  = r_beat + AMM_BURST_W'(1);
   assign w_unused    = ^op_pkt_i.low_burst_bits;

   // Beat count: zero length means one beat, boundary crossing adds one, then saturate
   always_comb begin
      w_base = (burst_len_i == '0) ? AMM_BURST_W'(1) : {1'b0, burst_len_i};
      w_len  = w_base + AMM_BURST_W'(BYTE_MODE & op_pkt_i.low_burst_bits[ADDR_B_W]);
      if (w_len > AMM_BURST_W'(MAX_LEN))
         w_len = AMM_BURST_W'(MAX_LEN);
   end

   // Byteenable is precomputed for the beat about to be presented
   assign w_be_start = w_accept ? op_pkt_i.start_offset : r_start;
   assign w_be_end   = w_accept ? op_pkt_i.end_offset   : r_end;
   assign w_be_beat  = w_accept ? '0                    : w_beat_nxt;
   assign w_be_len   = w_accept ? w_len                 : r_len;

   amm_be_gen #(.ADDR_TYPE(ADDR_TYPE)) u_be_gen (
      .i_start_off (w_be_start),
      .i_end_off   (w_be_end),
      .i_beat      (w_be_beat),
      .i_len       (w_be_len),
      .o_be        (w_be)
   );

   // Next-state: a started burst only ends once its last beat is taken
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE_S:     if (w_accept)
                        w_state_nxt = op_pkt_i.pkt_type ? RD_CMD_S : WR_BURST_S;
         WR_BURST_S: if (!amm_waitrequest_i && w_last) w_state_nxt = IDLE_S;
         RD_CMD_S:   if (!amm_waitrequest_i) w_state_nxt = IDLE_S;
         default:    w_state_nxt = IDLE_S;
      endcase
   end

   // State, ready and busy; busy stretches over the cycle the block returns to idle
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE_S;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == IDLE_S);
         r_busy  <= (w_state_nxt != IDLE_S) | (r_state != IDLE_S);
      end
   end

   // Command capture at accept and per-beat advance on each accepted write beat
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_addr    <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_start   <= '0;
         r_end     <= '0;
         r_pattern <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
      end else if (w_accept) begin
         r_addr    <= BYTE_MODE ? (op_pkt_i.word_addr << ADDR_B_W) : op_pkt_i.word_addr;
         r_len     <= w_len;
         r_beat    <= '0;
         r_start   <= op_pkt_i.start_offset;
         r_end     <= op_pkt_i.end_offset;
         r_pattern <= data_pattern_i;
         r_wdata   <= {DATA_W/32{data_pattern_i}};
         r_be      <= op_pkt_i.pkt_type ? '1 : w_be;
      end else if (w_beat_done && !w_last) begin
         r_beat    <= w_beat_nxt;
         r_wdata   <= {DATA_W/32{r_pattern + 32'(w_beat_nxt)}};
         r_be      <= w_be;
      end
   end

   assign cmd_accept_ready_o = r_ready;
   assign busy_o             = r_busy;
   assign amm_read_o         = (r_state == RD_CMD_S);
   assign amm_write_o        = (r_state == WR_BURST_S);
   assign amm_address_o      = r_addr;
   assign amm_burstcount_o   = r_len;
   assign amm_writedata_o    = r_wdata;
   assign amm_byteenable_o   = r_be;
endmodule

// File: tb/tb_amm_trans_block.sv
// Table-driven and randomized bench for amm_trans_block with a burst-level reference model.
module tb_amm_trans_block;
   import settings_pkg::*;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   op_valid_i;
   trans_struct_t          op_pkt_i;
   logic                   cmd_accept_ready_o;
   logic [AMM_BURST_W-2:0] burst_len_i;
   logic [31:0]            data_pattern_i;
   logic                   busy_o;
   logic [ADDR_W-1:0]      amm_address_o;
   logic                   amm_read_o, amm_write_o;
   logic [DATA_W-1:0]      amm_writedata_o;
   logic [BE_W-1:0]        amm_byteenable_o;
   logic [AMM_BURST_W-1:0] amm_burstcount_o;
   logic                   amm_waitrequest_i;

   int n_tests = 0;
   int n_fail  = 0;

   amm_trans_block dut (
      .clk_i(clk_i), .rst_i(rst_i), .op_valid_i(op_valid_i), .op_pkt_i(op_pkt_i),
      .cmd_accept_ready_o(cmd_accept_ready_o), .burst_len_i(burst_len_i),
      .data_pattern_i(data_pattern_i), .busy_o(busy_o), .amm_address_o(amm_address_o),
      .amm_read_o(amm_read_o), .amm_write_o(amm_write_o), .amm_writedata_o(amm_writedata_o),
      .amm_byteenable_o(amm_byteenable_o), .amm_burstcount_o(amm_burstcount_o),
      .amm_waitrequest_i(amm_waitrequest_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---- reference model: burst described by plain arithmetic ----
   function automatic int exp_len(input int bl, input bit carry);
      int l;
      l = (bl == 0) ? 1 : bl;
      l = l + int'(carry);
      if (l > MAX_LEN) l = MAX_LEN;
      return l;
   endfunction

   function automatic int exp_be(input int k, input int l, input int so, input int eo);
      int full, m;
      full = (1 << BE_W) - 1;
      m = full;
      if (k == 0)     m = m & ((full << so) & full);
      if (k == l - 1) m = m & (full >> (BE_W - 1 - eo));
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] exp_data(input logic [31:0] pat, input int k);
      logic [31:0] w;
      w = pat + 32'(k);
      return {DATA_W/32{w}};
   endfunction

   // waitrequest cycles inserted before a beat is taken
   function automatic int stall_for(input int mode, input int k);
      case (mode)
         1:       return (k == 1 || k == 2) ? 3 : 0;
         2:       return (k == 0) ? 5 : 0;
         3:       return int'($urandom_range(0, 2));
         default: return 0;
      endcase
   endfunction

   // Issue one command and check every strobe cycle against the model
   task automatic run_op(input bit typ, input logic [ADDR_W-1:0] waddr, input int bl,
                         input logic [31:0] pat, input int so, input int eo, input bit carry,
                         input int smode, output int o_bc, output int o_be0, output int o_bel);
      int l, beats, beat, stall_left, tot_stall, busy_n, guard;
      logic strobe;
      logic [ADDR_W-1:0] ea;
      l     = exp_len(bl, carry);
      beats = typ ? 1 : l;
      ea    = waddr << ADDR_B_W;
      o_bc = 0; o_be0 = 0; o_bel = 0;
      @(negedge clk_i);
      op_valid_i                = 1'b1;
      op_pkt_i.pkt_type         = typ;
      op_pkt_i.word_addr        = waddr;
      op_pkt_i.low_burst_bits   = ADDR_B_W'($urandom);
      op_pkt_i.low_burst_bits[ADDR_B_W] = carry;
      op_pkt_i.start_offset     = ADDR_B_W'(so);
      op_pkt_i.end_offset       = ADDR_B_W'(eo);
      burst_len_i               = (AMM_BURST_W-1)'(bl);
      data_pattern_i            = pat;
      amm_waitrequest_i         = 1'b0;
      guard = 0;
      while (!cmd_accept_ready_o && guard < 50) begin
         @(negedge clk_i);
         guard++;
      end
      chk("accept_in_time", guard < 50, 1);
      @(negedge clk_i);
      op_valid_i = 1'b0;
      op_pkt_i   = '0;
      beat = 0; stall_left = stall_for(smode, 0); tot_stall = stall_left;
      busy_n = 0; guard = 0;
      while (beat < beats && guard < 5000) begin
         if (busy_o) busy_n++;
         strobe = typ ? amm_read_o : amm_write_o;
         if (!strobe) begin
            chk("strobe_no_gap", strobe, 1);
            break;
         end
         chk("address", amm_address_o, ea);
         chk("burstcount", amm_burstcount_o, l);
         if (typ) begin
            chk("rd_byteenable", amm_byteenable_o, (1 << BE_W) - 1);
            chk("rd_no_write", amm_write_o, 0);
         end else begin
            chk("wr_data", amm_writedata_o, exp_data(pat, beat));
            chk("wr_byteenable", amm_byteenable_o, exp_be(beat, l, so, eo));
            chk("wr_no_read", amm_read_o, 0);
         end
         if (beat == 0)         o_be0 = int'(amm_byteenable_o);
         if (beat == beats - 1) o_bel = int'(amm_byteenable_o);
         o_bc = int'(amm_burstcount_o);
         if (stall_left > 0) begin
            amm_waitrequest_i = 1'b1;
            stall_left--;
         end else begin
            amm_waitrequest_i = 1'b0;
            beat++;
            if (beat < beats) begin
               stall_left = stall_for(smode, beat);
               tot_stall += stall_left;
            end
         end
         @(negedge clk_i);
         guard++;
      end
      amm_waitrequest_i = 1'b0;
      chk("strobes_low_after", {amm_read_o, amm_write_o}, 0);
      while (busy_o && guard < 5000) begin
         busy_n++;
         @(negedge clk_i);
         guard++;
      end
      chk("busy_cycles", busy_n, beats + tot_stall + 1);
   endtask

   typedef struct {
      bit          typ;
      logic [30:0] waddr;
      int          bl;
      logic [31:0] pat;
      int          so, eo;
      bit          carry;
      int          smode;
      int          exp_bc, exp_be0, exp_bel;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int bc, be0, bel, rd_n, viol_rr, viol_rdy, viol_bub, guard;
      logic prev_rd;

      vecs.push_back('{0, 31'h20, 4,    32'hA5A50000, 0, 7, 0, 0, 4,    8'hFF, 8'hFF});
      vecs.push_back('{0, 31'h20, 4,    32'hA5A50000, 0, 7, 0, 1, 4,    8'hFF, 8'hFF});
      vecs.push_back('{1, 31'h40, 8,    32'h0,        0, 7, 0, 2, 8,    8'hFF, 8'hFF});
      vecs.push_back('{0, 31'h11, 1,    32'h12345678, 3, 2, 1, 0, 2,    8'hF8, 8'h07});
      vecs.push_back('{0, 31'h12, 0,    32'h1,        2, 5, 0, 0, 1,    8'h3C, 8'h3C});
      vecs.push_back('{0, 31'h13, 3,    32'hDEAD0000, 7, 0, 1, 0, 4,    8'h80, 8'h01});
      vecs.push_back('{1, 31'h14, 0,    32'h0,        4, 4, 1, 0, 2,    8'hFF, 8'hFF});
      vecs.push_back('{0, 31'h15, 3,    32'hFFFFFFFE, 0, 7, 0, 3, 3,    8'hFF, 8'hFF});
      vecs.push_back('{0, 31'h16, 1023, 32'h00C0FFEE, 1, 6, 1, 0, 1024, 8'hFE, 8'h7F});

      rst_i = 1'b0; op_valid_i = 1'b0; op_pkt_i = '0; burst_len_i = '0;
      data_pattern_i = '0; amm_waitrequest_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk_i);
      chk("rst_ready", cmd_accept_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_strobes", {amm_read_o, amm_write_o}, 0);
      chk("rst_addr", amm_address_o, 0);
      chk("rst_be", amm_byteenable_o, 0);
      rst_i = 1'b1;
      @(negedge clk_i);
      chk("ready_after_rst", cmd_accept_ready_o, 1);

      // directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].typ, vecs[i].waddr, vecs[i].bl, vecs[i].pat, vecs[i].so, vecs[i].eo,
                vecs[i].carry, vecs[i].smode, bc, be0, bel);
         chk($sformatf("vec%0d_burstcount", i), bc, vecs[i].exp_bc);
         chk($sformatf("vec%0d_be_first", i), be0, vecs[i].exp_be0);
         chk($sformatf("vec%0d_be_last", i), bel, vecs[i].exp_bel);
      end

      // randomized ops against the model
      for (int n = 0; n < 40; n++) begin
         int rbl;
         rbl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6));
         run_op(1'($urandom), 31'($urandom), rbl, $urandom, int'($urandom_range(0, BE_W-1)),
                int'($urandom_range(0, BE_W-1)), 1'($urandom), 3, bc, be0, bel);
      end

      // back-to-back reads with op_valid held high: accepts alternate with a bubble
      @(negedge clk_i);
      op_valid_i = 1'b1;
      op_pkt_i = '0;
      op_pkt_i.pkt_type = 1'b1;
      burst_len_i = (AMM_BURST_W-1)'(1);
      guard = 0;
      while (!amm_read_o && guard < 10) begin
         @(negedge clk_i);
         guard++;
      end
      chk("b2b_first_read", amm_read_o, 1);
      rd_n = 0; viol_rr = 0; viol_rdy = 0; viol_bub = 0; prev_rd = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (amm_read_o) rd_n++;
         if (amm_read_o && prev_rd) viol_rr++;
         if (amm_read_o && cmd_accept_ready_o) viol_rdy++;
         if (!amm_read_o && !cmd_accept_ready_o) viol_bub++;
         prev_rd = amm_read_o;
         @(negedge clk_i);
      end
      op_valid_i = 1'b0;
      chk("b2b_read_count", rd_n, 5);
      chk("b2b_consecutive_reads", viol_rr, 0);
      chk("b2b_ready_while_busy", viol_rdy, 0);
      chk("b2b_ready_in_bubble", viol_bub, 0);
      repeat (3) @(negedge clk_i);

      // reset in the middle of a stalled L=4 write burst
      op_valid_i = 1'b1;
      op_pkt_i = '0;
      op_pkt_i.word_addr = 31'h20;
      burst_len_i = (AMM_BURST_W-1)'(4);
      data_pattern_i = 32'hA5A50000;
      amm_waitrequest_i = 1'b1;
      guard = 0;
      while (!amm_write_o && guard < 10) begin
         @(negedge clk_i);
         op_valid_i = 1'b0;
         guard++;
      end
      op_valid_i = 1'b0;
      chk("midrst_write_started", amm_write_o, 1);
      repeat (2) @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("midrst_write", amm_write_o, 0);
      chk("midrst_read", amm_read_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_ready", cmd_accept_ready_o, 0);
      chk("midrst_addr", amm_address_o, 0);
      chk("midrst_data", amm_writedata_o, 0);
      chk("midrst_be", amm_byteenable_o, 0);
      chk("midrst_burstcount", amm_burstcount_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      amm_waitrequest_i = 1'b0;
      #1 chk("ready_at_release", cmd_accept_ready_o, 0);
      @(negedge clk_i);
      chk("ready_cycle_after_release", cmd_accept_ready_o, 1);
      chk("write_idle_after_release", amm_write_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
